// File: rtl/beat_tone_pkg.sv
// beat_tone_pkg: shared types and constants for the beat tone player.
//   state_t      - player FSM states (IDLE, PLAY, GAP)
//   DEF_HALF_P*  - default half-periods in 50 MHz cycles (440/660/880/1320 Hz)
//   half_period  - maps a 2-bit beat intensity to one of four half-periods
//   max2         - helper for sizing counters from parameters
package beat_tone_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam int unsigned DEF_HALF_P0 = 56818;
    localparam int unsigned DEF_HALF_P1 = 37879;
    localparam int unsigned DEF_HALF_P2 = 28409;
    localparam int unsigned DEF_HALF_P3 = 18939;

    function automatic int unsigned half_period(
        input logic [1:0]  intensity,
        input int unsigned p0,
        input int unsigned p1,
        input int unsigned p2,
        input int unsigned p3
    );
        case (intensity)
            2'd0:    return p0;
            2'd1:    return p1;
            2'd2:    return p2;
            default: return p3;
        endcase
    endfunction

    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/beat_tone_player_sync.sv
// beat_sync_edge: brings the 10 ms-domain beat level and intensity into the
// clk domain and produces a one-cycle pulse on each rising edge of beat.
// Ports:
//   clk, rst_n     - system clock, asynchronous active-low reset
//   beat           - asynchronous beat level
//   beat_int       - asynchronous beat intensity
//   beat_edge      - one-cycle pulse on a synchronised rising edge of beat
//   beat_int_sync  - synchronised intensity, valid on the beat_edge cycle
module beat_sync_edge (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       beat,
    input  logic [1:0] beat_int,
    output logic       beat_edge,
    output logic [1:0] beat_int_sync
);

    logic       beat_s1, beat_s2, beat_d;
    logic [1:0] int_s1, int_s2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_s1 <= 1'b0;
            beat_s2 <= 1'b0;
            beat_d  <= 1'b0;
            int_s1  <= '0;
            int_s2  <= '0;
        end else begin
            beat_s1 <= beat;
            beat_s2 <= beat_s1;
            beat_d  <= beat_s2;
            int_s1  <= beat_int;
            int_s2  <= int_s1;
        end
    end

    assign beat_edge     = beat_s2 & ~beat_d;
    assign beat_int_sync = int_s2;

endmodule

// File: rtl/beat_tone_player.sv
// beat_tone_player: turns each detected beat into a timed square-wave burst.
// Pitch follows beat intensity; a silent gap follows each burst.
// Ports:
//   clk, rst_n  - 50 MHz system clock, asynchronous active-low reset
//   beat        - beat level from the beat generator (10 ms domain)
//   beat_int    - beat intensity, valid while beat is high
//   spk         - square-wave speaker drive
//   playing     - high while in PLAY
//   tone_sel    - intensity of the current or last burst
//   mute        - (only with BEAT_TONE_MUTE_EN) forces spk low, blocks new bursts
// Build option: define BEAT_TONE_MUTE_EN to add the mute input.
module beat_tone_player
    import beat_tone_pkg::*;
#(
    parameter int unsigned TONE_CYC = 5000000,
    parameter int unsigned GAP_CYC  = 1000000,
    parameter int unsigned HALF_P0  = DEF_HALF_P0,
    parameter int unsigned HALF_P1  = DEF_HALF_P1,
    parameter int unsigned HALF_P2  = DEF_HALF_P2,
    parameter int unsigned HALF_P3  = DEF_HALF_P3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       beat,
    input  logic [1:0] beat_int,
    output logic       spk,
    output logic       playing,
    output logic [1:0] tone_sel
`ifdef BEAT_TONE_MUTE_EN
    ,
    input  logic       mute
`endif
);

    localparam int unsigned HALF_MAX = max2(max2(HALF_P0, HALF_P1), max2(HALF_P2, HALF_P3));
    localparam int unsigned HW = $clog2(max2(HALF_MAX, 2));
    localparam int unsigned DW = $clog2(max2(TONE_CYC, 2));
    localparam int unsigned GW = $clog2(max2(GAP_CYC, 2));

    logic       beat_edge;
    logic [1:0] int_sync;

    beat_sync_edge u_sync (
        .clk           (clk),
        .rst_n         (rst_n),
        .beat          (beat),
        .beat_int      (beat_int),
        .beat_edge     (beat_edge),
        .beat_int_sync (int_sync)
    );

    state_t        state, state_n;
    logic [HW-1:0] half_cnt, half_n;
    logic [DW-1:0] dur_cnt, dur_n;
    logic [GW-1:0] gap_cnt, gap_n;
    logic          spk_q, spk_n;
    logic [1:0]    tone_q, tone_n;
    logic          accept, start;
    logic [HW-1:0] half_new, half_cur;

`ifdef BEAT_TONE_MUTE_EN
    assign accept = beat_edge & ~mute;
`else
    assign accept = beat_edge;
`endif

    assign half_new = HW'(half_period(int_sync, HALF_P0, HALF_P1, HALF_P2, HALF_P3) - 32'd1);
    assign half_cur = HW'(half_period(tone_q, HALF_P0, HALF_P1, HALF_P2, HALF_P3) - 32'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            half_cnt <= '0;
            dur_cnt  <= '0;
            gap_cnt  <= '0;
            spk_q    <= 1'b0;
            tone_q   <= '0;
        end else begin
            state    <= state_n;
            half_cnt <= half_n;
            dur_cnt  <= dur_n;
            gap_cnt  <= gap_n;
            spk_q    <= spk_n;
            tone_q   <= tone_n;
        end
    end

    always_comb begin
        state_n = state;
        half_n  = half_cnt;
        dur_n   = dur_cnt;
        gap_n   = gap_cnt;
        spk_n   = spk_q;
        tone_n  = tone_q;
        start   = 1'b0;
        case (state)
            IDLE: begin
                spk_n = 1'b0;
                start = accept;
            end
            PLAY: begin
                // A louder beat restarts the burst; this takes priority over expiry.
                if (accept && (int_sync > tone_q)) begin
                    start = 1'b1;
                end else if (dur_cnt == '0) begin
                    state_n = GAP;
                    spk_n   = 1'b0;
                    half_n  = '0;
                    gap_n   = GW'(GAP_CYC - 32'd1);
                end else begin
                    dur_n = dur_cnt - DW'(1);
                    if (half_cnt == '0) begin
                        spk_n  = ~spk_q;
                        half_n = half_cur;
                    end else begin
                        half_n = half_cnt - HW'(1);
                    end
                end
            end
            GAP: begin
                spk_n = 1'b0;
                if (gap_cnt == '0) begin
                    state_n = IDLE;
                end else begin
                    gap_n = gap_cnt - GW'(1);
                end
            end
            default: begin
                state_n = IDLE;
                spk_n   = 1'b0;
            end
        endcase
        if (start) begin
            state_n = PLAY;
            tone_n  = int_sync;
            half_n  = half_new;
            dur_n   = DW'(TONE_CYC - 32'd1);
            spk_n   = 1'b1;
        end
    end

    assign playing  = (state == PLAY);
    assign tone_sel = tone_q;
`ifdef BEAT_TONE_MUTE_EN
    assign spk = spk_q & ~mute;
`else
    assign spk = spk_q;
`endif

endmodule
